op_sequencer: RTL and testbench

//  Micro-program sequencer that drives the 4-bit opcode input of the datapath controller.
//  - Holds a small writable program of {opcode, repeat} words.
//  - On start, issues opcodes back-to-back, one per clock, with no bubbles.
//  - Stops on HALT, on a reserved opcode, or at the end of the program.
//  - Sits between host/test logic and the controller; the X/Y/Z/ALU datapath behind it is unchanged.

---
 rtl/op_pkg.sv | 18 +
 rtl/seq_prog_ram.sv | 23 ++
 rtl/op_sequencer.sv | 144 ++++++++++++++
 tb/tb_op_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/op_pkg.sv
// Shared opcode constants, FSM state type and opcode classification for the
// micro-program sequencer and the datapath controller it feeds.
package op_pkg;

  localparam logic [3:0] CLEAR_ADD   = 4'h0;
  localparam logic [3:0] ADD_LOAD    = 4'h1;
  localparam logic [3:0] ADD         = 4'h2;
  localparam logic [3:0] SHIFT_RIGHT = 4'h3;
  localparam logic [3:0] DISP        = 4'h4;
  localparam logic [3:0] HALT_NOP    = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op >= 4'h5) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// Program store for the sequencer: DEPTH words, asynchronous read, synchronous write.
module seq_prog_ram #(
  parameter int DEPTH  = 16,
  parameter int WORD_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/op_sequencer.sv
// Micro-program sequencer issuing {opcode, repeat} words back-to-back to the controller.
// Optional cycle counter output enabled by defining SEQ_CYCLE_CNT_EN.
module op_sequencer
  import op_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int OP_W   = 4,
  parameter int REP_W  = 4,
`ifdef SEQ_CYCLE_CNT_EN
  parameter int CNT_W  = 16,
`endif
  localparam int PC_W   = $clog2(DEPTH),
  localparam int WORD_W = OP_W + REP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [WORD_W-1:0] prog_wdata,
  output logic [OP_W-1:0]   opcode,
  output logic              op_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PC_W-1:0]   pc
`ifdef SEQ_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0]  cycles
`endif
);

  state_t            state, state_nxt;
  logic [REP_W-1:0]  rep_cnt;
  logic [PC_W-1:0]   pc_nxt, rd_addr;
  logic [WORD_W-1:0] rd_word;
  logic [OP_W-1:0]   rd_op;
  logic [REP_W-1:0]  rd_rep;
  logic              rd_halt, rd_resv, rd_issue, at_last, rep_done;

  seq_prog_ram #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_ram (
    .clock (clock),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // LOAD looks at word 0; RUN pre-decodes the following word so issue has no bubble
  assign pc_nxt   = pc + PC_W'(1);
  assign rd_addr  = (state == RUN) ? pc_nxt : '0;
  assign rd_op    = rd_word[WORD_W-1:REP_W];
  assign rd_rep   = rd_word[REP_W-1:0];
  assign rd_halt  = (rd_op == OP_W'(HALT_NOP));
  assign rd_resv  = is_reserved(rd_op);
  assign rd_issue = !rd_halt && !rd_resv;
  assign at_last  = (pc == PC_W'(DEPTH - 1));
  assign rep_done = (rep_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = LOAD;
        LOAD:    state_nxt = rd_issue ? RUN : DONE;
        RUN:     if (rep_done && (at_last || !rd_issue)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == LOAD) || (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode   <= OP_W'(HALT_NOP);
      op_valid <= 1'b0;
      err      <= 1'b0;
      pc       <= '0;
      rep_cnt  <= '0;
    end else if (abort) begin
      opcode   <= OP_W'(HALT_NOP);
      op_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            pc  <= '0;
          end
        end
        LOAD: begin
          if (rd_issue) begin
            opcode   <= rd_op;
            op_valid <= 1'b1;
            rep_cnt  <= rd_rep;
          end else if (rd_resv) begin
            err <= 1'b1;
          end
        end
        RUN: begin
          if (!rep_done) begin
            rep_cnt <= rep_cnt - REP_W'(1);
          end else if (at_last || !rd_issue) begin
            opcode   <= OP_W'(HALT_NOP);
            op_valid <= 1'b0;
            if (!at_last && rd_resv) err <= 1'b1;
          end else begin
            opcode  <= rd_op;
            rep_cnt <= rd_rep;
            pc      <= pc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  // Start is only accepted in IDLE, where op_valid is low, so clear and count never collide
  always_ff @(posedge clock) begin
    if (reset)
      cycles <= '0;
    else if (state == IDLE && start && !abort)
      cycles <= '0;
    else if (op_valid && (cycles != '1))
      cycles <= cycles + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: a program-walk model produces the per-cycle output trace
// which a negedge compare process checks against the DUT.
module tb_op_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, abort, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic [3:0] opcode;
  logic       op_valid, busy, done, err;
  logic [3:0] pc;
`ifdef SEQ_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif

  op_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .opcode     (opcode),
    .op_valid   (op_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc         (pc)
`ifdef SEQ_CYCLE_CNT_EN
    ,
    .cycles     (cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] opcode;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] pc;
    bit         chk_pc;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] shadow [16];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         nv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic v, input logic b,
                              input logic d, input logic e, input int p,
                              input bit cp, input int c);
    exp_t x;
    x.opcode = op; x.valid = v; x.busy = b; x.done = d; x.err = e;
    x.pc = p[3:0]; x.chk_pc = cp; x.cyc = c;
    return x;
  endfunction

  // Walk the shadow program: LOAD cycle, rep+1 issues per word, then DONE and one IDLE cycle
  task automatic build(input int keep, output int nvalid);
    exp_t       tmp[$];
    int         n, lastpc, rep, lim;
    logic       er;
    logic [3:0] op;
    n = 0; lastpc = 0; er = 1'b0;
    tmp.push_back(mk(4'hF, 0, 1, 0, 0, 0, 1, 0));
    for (int j = 0; j < 16; j++) begin
      op  = shadow[j][7:4];
      rep = int'(shadow[j][3:0]);
      if (op == 4'hF) break;
      if (op >= 4'h5 && op <= 4'hE) begin er = 1'b1; break; end
      for (int r = 0; r <= rep; r++) begin
        tmp.push_back(mk(op, 1, 1, 0, 0, j, 1, n));
        n++;
      end
      lastpc = j;
    end
    tmp.push_back(mk(4'hF, 0, 0, 1, er, lastpc, 1, n));
    tmp.push_back(mk(4'hF, 0, 0, 0, er, lastpc, 1, n));
    lim = (keep < 0) ? tmp.size() : keep;
    for (int i = 0; i < lim; i++) exp_q.push_back(tmp[i]);
    nvalid = n;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("opcode", opcode, cur.opcode);
      chk("op_valid", op_valid, cur.valid);
      chk("busy", busy, cur.busy);
      chk("done", done, cur.done);
      chk("err", err, cur.err);
      if (cur.chk_pc) chk("pc", pc, cur.pc);
`ifdef SEQ_CYCLE_CNT_EN
      if (cur.cyc >= 0) chk("cycles", cycles, cur.cyc);
`endif
    end
  end

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clock); #1;
    prog_we = 1'b1; prog_addr = a[3:0]; prog_wdata = d; shadow[a] = d;
    @(negedge clock); #1;
    prog_we = 1'b0;
  endtask

  task automatic launch(input int keep, output int nvalid);
    @(negedge clock); #1;
    start = 1'b1;
    build(keep, nvalid);
    @(negedge clock); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
    chk("trace_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_idle(input int n, input logic e);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(4'hF, 0, 0, 0, e, 0, 0, -1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'hF0;
    repeat (3) @(negedge clock);
    chk("rst_opcode", opcode, 4'hF);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_pc", pc, 4'h0);
    #1 reset = 1'b0;

    // Basic program with a repeat and explicit HALT
    for (int i = 0; i < 16; i++) wr(i, 8'hF0);
    wr(0, 8'h00); wr(1, 8'h10); wr(2, 8'h22); wr(3, 8'h30); wr(4, 8'h40);
    launch(-1, nv);
    chk("s1_nvalid", nv, 7);
    drain();
`ifdef SEQ_CYCLE_CNT_EN
    chk("s1_cycles", cycles, 7);
`endif

    // Write and start while busy are both ignored; readback run proves memory intact
    launch(-1, nv);
    @(negedge clock); #1;
    prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 8'h25; start = 1'b1;
    @(negedge clock); #1;
    prog_we = 1'b0; start = 1'b0;
    drain();
    launch(-1, nv);
    chk("s5_readback_nvalid", nv, 7);
    drain();

    // start together with abort in IDLE: abort wins
    @(negedge clock); #1;
    start = 1'b1; abort = 1'b1;
    push_idle(3, 1'b0);
    @(negedge clock); #1;
    start = 1'b0; abort = 1'b0;
    drain();

    // Reset mid-run
    launch(4, nv);
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    exp_q.push_back(mk(4'hF, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(4'hF, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clock); #1;
    reset = 1'b0;
    drain();

    // Abort in the second issue cycle of a repeated word
    wr(0, 8'h23); wr(1, 8'h40); wr(2, 8'hF0);
    launch(3, nv);
    repeat (2) @(negedge clock);
    #1 abort = 1'b1;
    push_idle(3, 1'b0);
    @(negedge clock); #1;
    abort = 1'b0;
    drain();

    // Reserved opcode in word 0: err sticks until the next start
    wr(0, 8'h50);
    launch(-1, nv);
    chk("s2_nvalid", nv, 0);
    drain();
    repeat (3) @(negedge clock);
    chk("s2_err_sticky", err, 1'b1);

    // Full program without HALT: implicit stop at the last word
    for (int i = 0; i < 16; i++) wr(i, 8'h20);
    launch(-1, nv);
    chk("s3_nvalid", nv, 16);
    drain();
    chk("s3_err", err, 1'b0);

    // Reserved opcode mid-program
    wr(3, 8'h90);
    launch(-1, nv);
    chk("mid_resv_nvalid", nv, 3);
    drain();
    chk("mid_resv_err", err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
